aurora_block_scheduler: RTL and testbench

- Per-block arbiter/sequencer feeding the Aurora 64b/66b priority mux for one lane group.
- On each gearbox block-slot acknowledge, it chooses which block type occupies the next 66b slot: channel bonding, clock compensation, native/user flow control, UserK, user data or idle.
- It generates the periodic CB and CC bursts internally and grants external requesters by fixed priority, with an optional data anti-starvation guard.
- It sits between the lane-init/data/UserK FSMs and the priority mux/scrambler.

---
 rtl/aurora_sched_pkg.sv | 29 ++
 rtl/aurora_sched_burst_timer.sv | 85 ++++++++
 rtl/aurora_block_scheduler.sv | 148 ++++++++++++++
 tb/tb_aurora_block_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_sched_pkg.sv
// Shared slot-type and requester encodings for the Aurora block scheduler.
// The optional data anti-starvation guard is enabled with AURORA_SCHED_STARVE_GUARD_EN.
package aurora_sched_pkg;

   localparam int NSLOTS = 7;
   localparam int NREQ   = 4;

   typedef enum logic [2:0] {
      SLOT_CB    = 3'd0,
      SLOT_CC    = 3'd1,
      SLOT_NFC   = 3'd2,
      SLOT_UFC   = 3'd3,
      SLOT_USERK = 3'd4,
      SLOT_DATA  = 3'd5,
      SLOT_IDLE  = 3'd6
   } slot_e;

   localparam int REQ_NFC   = 0;
   localparam int REQ_UFC   = 1;
   localparam int REQ_USERK = 2;
   localparam int REQ_DATA  = 3;

   localparam logic [NSLOTS-1:0] GRANT_IDLE = 7'b1000000;

   function automatic logic [NSLOTS-1:0] slot_bit(input slot_e slot);
      return {{(NSLOTS-1){1'b0}}, 1'b1} << slot;
   endfunction

endpackage

// File: rtl/aurora_sched_burst_timer.sv
// Periodic burst sequencer: counts acks between bursts, then holds Pending
// until max(Send,1) slots of its own type have been consumed.
module aurora_sched_burst_timer
   import aurora_sched_pkg::*;
#(
   parameter int WAIT_W = 4,
   parameter int SEND_W = 4
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Ack,
   input  logic              Clear,
   input  logic [WAIT_W-1:0] Wait,
   input  logic [SEND_W-1:0] Send,
   input  logic              SlotSent,
   output logic              Pending,
   output logic              PendingNext
);

   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_nxt_s;
   logic [WAIT_W-1:0] wait_inc_s;
   logic [SEND_W-1:0] burst_cnt_r;
   logic [SEND_W-1:0] burst_cnt_nxt_s;
   logic [SEND_W-1:0] send_eff_s;
   logic [SEND_W:0]   burst_inc_s;
   logic              pending_r;
   logic              pending_nxt_s;

   // Next-state of wait/burst counters and the pending flag.
   always_comb begin
      wait_cnt_nxt_s  = wait_cnt_r;
      burst_cnt_nxt_s = burst_cnt_r;
      pending_nxt_s   = pending_r;
      send_eff_s      = (Send == {SEND_W{1'b0}}) ? {{(SEND_W-1){1'b0}}, 1'b1} : Send;
      wait_inc_s      = (wait_cnt_r == {WAIT_W{1'b1}}) ? wait_cnt_r
                                                       : wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      burst_inc_s     = {1'b0, burst_cnt_r} + {{SEND_W{1'b0}}, 1'b1};
      if (Clear) begin
         wait_cnt_nxt_s  = {WAIT_W{1'b0}};
         burst_cnt_nxt_s = {SEND_W{1'b0}};
         pending_nxt_s   = 1'b0;
      end else if (Ack) begin
         if (pending_r) begin
            if (SlotSent) begin
               if (burst_inc_s >= {1'b0, send_eff_s}) begin
                  burst_cnt_nxt_s = {SEND_W{1'b0}};
                  pending_nxt_s   = 1'b0;
               end else begin
                  burst_cnt_nxt_s = burst_inc_s[SEND_W-1:0];
               end
            end else begin
               burst_cnt_nxt_s = burst_cnt_r;
            end
         end else begin
            // >= rather than == so a Wait lowered below the count fires now
            if ((Wait != {WAIT_W{1'b0}}) && (wait_inc_s >= Wait)) begin
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
               pending_nxt_s  = 1'b1;
            end else begin
               wait_cnt_nxt_s = wait_inc_s;
            end
         end
      end else begin
         pending_nxt_s = pending_r;
      end
   end

   // Timer state registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wait_cnt_r  <= {WAIT_W{1'b0}};
         burst_cnt_r <= {SEND_W{1'b0}};
         pending_r   <= 1'b0;
      end else begin
         wait_cnt_r  <= wait_cnt_nxt_s;
         burst_cnt_r <= burst_cnt_nxt_s;
         pending_r   <= pending_nxt_s;
      end
   end

   assign Pending     = pending_r;
   assign PendingNext = pending_nxt_s;

endmodule

// File: rtl/aurora_block_scheduler.sv
// Per-block slot arbiter for the Aurora 64b/66b priority mux (CB > CC > NFC > UFC > USERK > DATA > IDLE).
// Define AURORA_SCHED_STARVE_GUARD_EN to promote a starved DATA requester above USERK.
module aurora_block_scheduler
   import aurora_sched_pkg::*;
#(
   parameter int CCW_WIDTH = 4,
   parameter int CCS_WIDTH = 4,
   parameter int CBW_WIDTH = 20,
   parameter int CBS_WIDTH = 4,
   parameter int STV_WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 LaneReady,
   input  logic                 AuroraAck,
   input  logic [CCW_WIDTH-1:0] CCWait,
   input  logic [CCS_WIDTH-1:0] CCSend,
   input  logic [CBW_WIDTH-1:0] CBWait,
   input  logic [CBS_WIDTH-1:0] CBSend,
   input  logic [NREQ-1:0]      Req,
   input  logic [STV_WIDTH-1:0] StarveLimit,
   output logic [NSLOTS-1:0]    Grant,
   output logic [NSLOTS-1:0]    Sent,
   output logic                 CBActive
);

   logic              ack_s;
   logic              clear_s;
   logic              cb_pend_r;
   logic              cb_pend_nxt_s;
   logic              cc_pend_nxt_s;
   logic              unused_cc_pend_s;
   logic              data_promote_s;
   logic [NSLOTS-1:0] grant_r;
   logic [NSLOTS-1:0] sent_r;
   logic [NSLOTS-1:0] grant_nxt_s;

   assign ack_s   = AuroraAck & LaneReady;
   assign clear_s = ~LaneReady;

   aurora_sched_burst_timer #(
      .WAIT_W (CBW_WIDTH),
      .SEND_W (CBS_WIDTH)
   ) u_cb_timer (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Ack         (ack_s),
      .Clear       (clear_s),
      .Wait        (CBWait),
      .Send        (CBSend),
      .SlotSent    (grant_r[SLOT_CB]),
      .Pending     (cb_pend_r),
      .PendingNext (cb_pend_nxt_s)
   );

   // CC only ever counts while no CC burst is pending, so a CB burst that
   // pre-empts it leaves its wait count frozen automatically.
   aurora_sched_burst_timer #(
      .WAIT_W (CCW_WIDTH),
      .SEND_W (CCS_WIDTH)
   ) u_cc_timer (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Ack         (ack_s),
      .Clear       (clear_s),
      .Wait        (CCWait),
      .Send        (CCSend),
      .SlotSent    (grant_r[SLOT_CC]),
      .Pending     (unused_cc_pend_s),
      .PendingNext (cc_pend_nxt_s)
   );

`ifdef AURORA_SCHED_STARVE_GUARD_EN
   logic [STV_WIDTH-1:0] stv_cnt_r;

   assign data_promote_s = (StarveLimit != {STV_WIDTH{1'b0}}) && (stv_cnt_r >= StarveLimit);

   // Consecutive DATA losses, saturating.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         stv_cnt_r <= {STV_WIDTH{1'b0}};
      end else if (!LaneReady) begin
         stv_cnt_r <= {STV_WIDTH{1'b0}};
      end else if (AuroraAck) begin
         if (Req[REQ_DATA] && !grant_nxt_s[SLOT_DATA]) begin
            if (stv_cnt_r != {STV_WIDTH{1'b1}}) begin
               stv_cnt_r <= stv_cnt_r + {{(STV_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               stv_cnt_r <= stv_cnt_r;
            end
         end else begin
            stv_cnt_r <= {STV_WIDTH{1'b0}};
         end
      end else begin
         stv_cnt_r <= stv_cnt_r;
      end
   end
`else
   logic unused_stv_s;

   assign unused_stv_s   = ^StarveLimit;
   assign data_promote_s = 1'b0;
`endif

   // Fixed-priority pick for the slot following the current ack.
   always_comb begin
      grant_nxt_s = GRANT_IDLE;
      if (cb_pend_nxt_s) begin
         grant_nxt_s = slot_bit(SLOT_CB);
      end else if (cc_pend_nxt_s) begin
         grant_nxt_s = slot_bit(SLOT_CC);
      end else if (Req[REQ_NFC]) begin
         grant_nxt_s = slot_bit(SLOT_NFC);
      end else if (Req[REQ_UFC]) begin
         grant_nxt_s = slot_bit(SLOT_UFC);
      end else if (data_promote_s && Req[REQ_DATA]) begin
         grant_nxt_s = slot_bit(SLOT_DATA);
      end else if (Req[REQ_USERK]) begin
         grant_nxt_s = slot_bit(SLOT_USERK);
      end else if (Req[REQ_DATA]) begin
         grant_nxt_s = slot_bit(SLOT_DATA);
      end else begin
         grant_nxt_s = GRANT_IDLE;
      end
   end

   // Grant/Sent output registers; Sent pulses only on a qualified ack.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         grant_r <= GRANT_IDLE;
         sent_r  <= {NSLOTS{1'b0}};
      end else if (!LaneReady) begin
         grant_r <= GRANT_IDLE;
         sent_r  <= {NSLOTS{1'b0}};
      end else if (AuroraAck) begin
         grant_r <= grant_nxt_s;
         sent_r  <= grant_r;
      end else begin
         grant_r <= grant_r;
         sent_r  <= {NSLOTS{1'b0}};
      end
   end

   assign Grant    = grant_r;
   assign Sent     = sent_r;
   assign CBActive = cb_pend_r;

endmodule

// File: tb/tb_aurora_block_scheduler.sv
// Self-checking bench for aurora_block_scheduler: a burst-countdown model checked
// every cycle, plus directed phases with hand-computed slot sequences.
module tb_aurora_block_scheduler;

   localparam logic [6:0] G_CB   = 7'b0000001;
   localparam logic [6:0] G_CC   = 7'b0000010;
   localparam logic [6:0] G_NFC  = 7'b0000100;
   localparam logic [6:0] G_UFC  = 7'b0001000;
   localparam logic [6:0] G_UK   = 7'b0010000;
   localparam logic [6:0] G_DATA = 7'b0100000;
   localparam logic [6:0] G_IDLE = 7'b1000000;
   localparam int CC_MAX  = 15;
   localparam int CB_MAX  = 1048575;
   localparam int STV_MAX = 255;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        LaneReady = 1'b1;
   logic        AuroraAck = 1'b0;
   logic [3:0]  CCWait = 4'd0;
   logic [3:0]  CCSend = 4'd0;
   logic [19:0] CBWait = 20'd0;
   logic [3:0]  CBSend = 4'd0;
   logic [3:0]  Req = 4'd0;
   logic [7:0]  StarveLimit = 8'd0;
   logic [6:0]  Grant;
   logic [6:0]  Sent;
   logic        CBActive;

   int checks = 0;
   int errors = 0;

   // model state: blocks left in the pending burst (0 = none) and acks counted
   logic [6:0] m_grant = G_IDLE;
   logic [6:0] m_sent  = 7'd0;
   int m_cc_acks = 0, m_cc_left = 0, m_cb_acks = 0, m_cb_left = 0, m_stv = 0;

   always #5 Clk = ~Clk;

   aurora_block_scheduler dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .LaneReady   (LaneReady),
      .AuroraAck   (AuroraAck),
      .CCWait      (CCWait),
      .CCSend      (CCSend),
      .CBWait      (CBWait),
      .CBSend      (CBSend),
      .Req         (Req),
      .StarveLimit (StarveLimit),
      .Grant       (Grant),
      .Sent        (Sent),
      .CBActive    (CBActive)
   );

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_grant = G_IDLE; m_sent = 7'd0;
      m_cc_acks = 0; m_cc_left = 0; m_cb_acks = 0; m_cb_left = 0; m_stv = 0;
   endtask

   task automatic model_step();
      logic [6:0] consumed;
      logic promote;
      if (!Rst_n || !LaneReady) begin
         model_clear();
      end else if (AuroraAck) begin
         consumed = m_grant;
         m_sent   = consumed;
         if (m_cb_left > 0) begin
            if (consumed == G_CB) m_cb_left--;
         end else begin
            if (m_cb_acks < CB_MAX) m_cb_acks++;
            if (CBWait != 20'd0 && m_cb_acks >= int'(CBWait)) begin
               m_cb_left = (CBSend == 4'd0) ? 1 : int'(CBSend);
               m_cb_acks = 0;
            end
         end
         if (m_cc_left > 0) begin
            if (consumed == G_CC) m_cc_left--;
         end else begin
            if (m_cc_acks < CC_MAX) m_cc_acks++;
            if (CCWait != 4'd0 && m_cc_acks >= int'(CCWait)) begin
               m_cc_left = (CCSend == 4'd0) ? 1 : int'(CCSend);
               m_cc_acks = 0;
            end
         end
`ifdef AURORA_SCHED_STARVE_GUARD_EN
         promote = (StarveLimit != 8'd0) && (m_stv >= int'(StarveLimit));
`else
         promote = 1'b0;
`endif
         if (m_cb_left > 0)          m_grant = G_CB;
         else if (m_cc_left > 0)     m_grant = G_CC;
         else if (Req[0])            m_grant = G_NFC;
         else if (Req[1])            m_grant = G_UFC;
         else if (promote && Req[3]) m_grant = G_DATA;
         else if (Req[2])            m_grant = G_UK;
         else if (Req[3])            m_grant = G_DATA;
         else                        m_grant = G_IDLE;
         if (Req[3] && m_grant != G_DATA) m_stv = (m_stv < STV_MAX) ? m_stv + 1 : m_stv;
         else m_stv = 0;
      end else begin
         m_sent = 7'd0;
      end
   endtask

   initial forever begin
      @(posedge Clk);
      model_step();
   end

   // per-cycle comparison against the model (or reset literals while in reset)
   initial forever begin
      @(negedge Clk);
      if (!Rst_n) begin
         check("rst_grant", Grant, G_IDLE);
         check("rst_sent", Sent, 7'd0);
         check("rst_cbactive", {6'd0, CBActive}, 7'd0);
      end else begin
         check("model_grant", Grant, m_grant);
         check("model_sent", Sent, m_sent);
         check("model_cbactive", {6'd0, CBActive}, {6'd0, (m_cb_left > 0)});
      end
   end

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic do_ack(output logic [6:0] g, output logic [6:0] s);
      tick();
      AuroraAck = 1'b1;
      tick();
      AuroraAck = 1'b0;
      g = Grant;
      s = Sent;
   endtask

   task automatic restart(input logic [3:0] ccw, input logic [3:0] ccs, input logic [19:0] cbw,
                          input logic [3:0] cbs, input logic [3:0] rq, input logic [7:0] stl);
      tick();
      LaneReady = 1'b0;
      CCWait = ccw; CCSend = ccs; CBWait = cbw; CBSend = cbs; Req = rq; StarveLimit = stl;
      tick();
      tick();
      LaneReady = 1'b1;
   endtask

   function automatic logic [6:0] cc_phase_exp(input int i);
      if (i <= 0) return G_IDLE;
      return ((i % 6) == 4 || (i % 6) == 5) ? G_CC : G_IDLE;
   endfunction

   initial begin
      logic [6:0] g, s, prev;
      int uk_sent;

      // reset and idle behaviour
      tick(); tick(); tick();
      Rst_n = 1'b1;
      tick();
      check("post_rst_grant", Grant, G_IDLE);
      check("post_rst_sent", Sent, 7'd0);
      for (int i = 1; i <= 3; i++) begin
         do_ack(g, s);
         check($sformatf("idle_grant%0d", i), g, G_IDLE);
         check($sformatf("idle_sent%0d", i), s, G_IDLE);
      end

      // periodic CC: 4 waits, 2-slot bursts, period 6
      restart(4'd4, 4'd2, 20'd0, 4'd0, 4'd0, 8'd0);
      for (int i = 1; i <= 12; i++) begin
         do_ack(g, s);
         check($sformatf("cc_grant%0d", i), g, cc_phase_exp(i));
         check($sformatf("cc_sent%0d", i), s, cc_phase_exp(i - 1));
      end

      // CB and CC due together: CB first, CC frozen behind it
      restart(4'd3, 4'd1, 20'd3, 4'd1, 4'd0, 8'd0);
      for (int i = 1; i <= 6; i++) begin
         do_ack(g, s);
         check($sformatf("cbcc_grant%0d", i), g, (i == 3) ? G_CB : (i == 4) ? G_CC : G_IDLE);
         check($sformatf("cbcc_active%0d", i), {6'd0, CBActive}, {6'd0, (i == 3)});
      end

      // USERK then DATA with no gap slot
      restart(4'd0, 4'd0, 20'd0, 4'd0, 4'b1100, 8'd0);
      uk_sent = 0;
      prev = G_IDLE;
      for (int i = 1; i <= 5; i++) begin
         do_ack(g, s);
         check($sformatf("uk_grant%0d", i), g, (i <= 3) ? G_UK : G_DATA);
         check($sformatf("uk_sent%0d", i), s, prev);
         prev = (i <= 3) ? G_UK : G_DATA;
         if (s == G_UK) uk_sent++;
         if (uk_sent == 2) Req[2] = 1'b0;
      end

      // LaneReady drop mid CC burst, then a full-length burst after re-entry
      restart(4'd3, 4'd4, 20'd0, 4'd0, 4'd0, 8'd0);
      for (int i = 1; i <= 5; i++) begin
         do_ack(g, s);
         check($sformatf("lr_pre%0d", i), g, (i >= 3) ? G_CC : G_IDLE);
      end
      tick();
      LaneReady = 1'b0;
      tick();
      check("lr_drop_grant", Grant, G_IDLE);
      check("lr_drop_sent", Sent, 7'd0);
      LaneReady = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         do_ack(g, s);
         check($sformatf("lr_post%0d", i), g, (i >= 3 && i <= 6) ? G_CC : G_IDLE);
      end

      // saturating count, CCWait lowered below it fires at once; CCSend=0 means 1
      restart(4'd0, 4'd0, 20'd0, 4'd0, 4'd0, 8'd0);
      for (int i = 1; i <= 5; i++) do_ack(g, s);
      CCWait = 4'd2;
      do_ack(g, s);
      check("lower_wait_fire", g, G_CC);
      do_ack(g, s);
      check("send0_one_slot", g, G_IDLE);
      do_ack(g, s);
      check("rewait1", g, G_IDLE);
      do_ack(g, s);
      check("rewait2", g, G_CC);

      // async reset mid burst abandons it
      restart(4'd2, 4'd3, 20'd0, 4'd0, 4'd0, 8'd0);
      for (int i = 1; i <= 3; i++) do_ack(g, s);
      check("pre_rst_burst", g, G_CC);
      Rst_n = 1'b0;
      tick();
      tick();
      Rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         do_ack(g, s);
         check($sformatf("rst_burst%0d", i), g, (i >= 2 && i <= 4) ? G_CC : G_IDLE);
      end

      // starvation guard
      restart(4'd0, 4'd0, 20'd0, 4'd0, 4'b1100, 8'd3);
      for (int i = 1; i <= 8; i++) begin
         do_ack(g, s);
`ifdef AURORA_SCHED_STARVE_GUARD_EN
         check($sformatf("stv_grant%0d", i), g, ((i % 4) == 0) ? G_DATA : G_UK);
`else
         check($sformatf("stv_grant%0d", i), g, G_UK);
`endif
      end

      // mixed traffic against the model only
      restart(4'd2, 4'd3, 20'd5, 4'd2, 4'b1111, 8'd2);
      for (int i = 1; i <= 24; i++) begin
         if ((i % 3) == 0) Req = 4'($urandom_range(0, 15));
         do_ack(g, s);
      end
      Req = 4'd2;
      do_ack(g, s);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
